f1_light_sequencer: RTL and testbench

Parametrised successor to the fixed F1 start-light chain: an internal prescaler paces a start-light fill sequence of configurable length, holds all lights on for a pseudo-random number of ticks, then extinguishes them and flags "lights out". One instance drives the light bar directly from the top level. It adds a start trigger, a random hold, status outputs and restartable pacing. None of these exist in the fixed-width predecessor.

---
 rtl/f1_seq_pkg.sv | 31 +++
 rtl/f1_lfsr.sv | 39 +++
 rtl/f1_light_sequencer.sv | 140 ++++++++++++++
 tb/tb_f1_light_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : f1_seq_pkg
// Description : Shared types and helpers for the F1 start-light sequencer:
//               sequencer state encoding and LFSR tap masks.
// Revision    : 1.0 - initial release
// ============================================================================
package f1_seq_pkg;

    // Sequencer states; width fixed so the encoding is explicit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Fibonacci tap mask for a maximal-length LFSR of width k (4..8).
    // Bit (e-1) set means x^e is a term of the polynomial.
    function automatic logic [7:0] lfsr_taps(input int k);
        case (k)
            4:       return 8'h0C;  // x^4 + x^3 + 1
            5:       return 8'h14;  // x^5 + x^3 + 1
            6:       return 8'h30;  // x^6 + x^5 + 1
            7:       return 8'h60;  // x^7 + x^6 + 1
            8:       return 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1
            default: return 8'h60;
        endcase
    endfunction

endpackage : f1_seq_pkg
`default_nettype wire

// File: rtl/f1_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : f1_lfsr
// Description : Free-running Fibonacci LFSR, seeded with 1 on reset and
//               stepped on every enabled clock. Never reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module f1_lfsr
    import f1_seq_pkg::*;
#(
    parameter int K_WIDTH = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [K_WIDTH-1:0] q
);

    localparam logic [7:0]         c_taps_all = lfsr_taps(K_WIDTH);
    localparam logic [K_WIDTH-1:0] c_taps     = c_taps_all[K_WIDTH-1:0];

    logic [K_WIDTH-1:0] r_q;
    logic               w_fb;

    assign w_fb = ^(r_q & c_taps);

    // Shift left, feeding the tap parity into bit 0; hold when disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= K_WIDTH'(1);
        end else if (en) begin
            r_q <= {r_q[K_WIDTH-2:0], w_fb};
        end
    end

    assign q = r_q;

endmodule : f1_lfsr
`default_nettype wire

// File: rtl/f1_light_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : f1_light_sequencer
// Description : F1 start-light sequencer. A prescaler paces a left-fill of
//               D_WIDTH lights, all lights are then held for a pseudo-random
//               number of ticks, after which they extinguish and a one-cycle
//               lights_out pulse is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module f1_light_sequencer
    import f1_seq_pkg::*;
#(
    parameter int N_WIDTH = 16,
    parameter int D_WIDTH = 8,
    parameter int K_WIDTH = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               trigger,
    input  logic [N_WIDTH-1:0] N,
    output logic [D_WIDTH-1:0] data_out,
    output logic               busy,
    output logic               lights_out
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_WIDTH-1:0] r_cnt;
    logic [N_WIDTH-1:0] w_cnt_nxt;
    logic [D_WIDTH-1:0] r_data;
    logic [D_WIDTH-1:0] w_data_nxt;
    logic [K_WIDTH-1:0] r_h;
    logic [K_WIDTH-1:0] w_h_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_lo;
    logic               w_lo_nxt;
    logic               w_accept;
    logic               w_tick;
    logic [K_WIDTH-1:0] w_lfsr_q;

    // Random source for the hold length; runs whenever en is high.
    f1_lfsr #(
        .K_WIDTH(K_WIDTH)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .q   (w_lfsr_q)
    );

    // A tick fires on every enabled cycle in which the prescaler sits at zero.
    assign w_tick = en && (r_cnt == '0);

    // Prescaler: reload N on trigger acceptance and after each tick, else count down.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (en) begin
            if (w_accept || (r_cnt == '0)) begin
                w_cnt_nxt = N;
            end else begin
                w_cnt_nxt = r_cnt - N_WIDTH'(1);
            end
        end
    end

    // Next-state and output logic for the fill/hold sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_busy_nxt  = r_busy;
        w_h_nxt     = r_h;
        w_lo_nxt    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_data_nxt = '0;
                w_busy_nxt = 1'b0;
                if (en && trigger) begin
                    w_accept    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (w_tick) begin
                    w_data_nxt = {r_data[D_WIDTH-2:0], 1'b1};
                    // This tick lights the final lamp: start the random hold.
                    if (&r_data[D_WIDTH-2:0]) begin
                        w_h_nxt     = w_lfsr_q;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    if (r_h == K_WIDTH'(1)) begin
                        w_data_nxt  = '0;
                        w_lo_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_h_nxt = r_h - K_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_data_nxt  = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_h     <= '0;
            r_busy  <= 1'b0;
            r_lo    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_h     <= w_h_nxt;
            r_busy  <= w_busy_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign data_out   = r_data;
    assign busy       = r_busy;
    assign lights_out = r_lo;

endmodule : f1_light_sequencer
`default_nettype wire

// File: tb/tb_f1_light_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_f1_light_sequencer
// Description : Self-checking bench for f1_light_sequencer. Two instances
//               (K_WIDTH 7 and 4) share one stimulus stream; a reference
//               model feeds per-cycle expectations into scoreboard queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f1_light_sequencer;

    typedef struct packed {
        logic [7:0] data;
        logic       busy;
        logic       lo;
    } exp_t;

    typedef struct packed {
        bit         rst;
        bit         en;
        bit         trig;
        logic [7:0] data;
        bit         busy;
        bit         lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        trigger;
    logic [15:0] n;
    logic [7:0]  d7, d4;
    logic        b7, b4, l7, l4;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state, index 0 = K_WIDTH 7, index 1 = K_WIDTH 4.
    int         kw[2] = '{7, 4};
    logic [7:0] m_data[2];
    bit         m_busy[2];
    bit         m_lo[2];
    int         m_lfsr[2];
    int         m_cnt[2];
    int         m_per[2];
    int         m_h[2];

    exp_t sb7[$];
    exp_t sb4[$];

    // Hold-length monitor on the K_WIDTH 4 instance (meaningful with N=0).
    bit         hmon    = 0;
    int         hstart  = 0;
    int         hseq    = 0;
    logic [7:0] prev_d4 = 8'h00;

    vec_t tbl[12];

    always #5 clk = ~clk;

    f1_light_sequencer #(.N_WIDTH(16), .D_WIDTH(8), .K_WIDTH(7)) u_dut7 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .trigger    (trigger),
        .N          (n),
        .data_out   (d7),
        .busy       (b7),
        .lights_out (l7)
    );

    f1_light_sequencer #(.N_WIDTH(16), .D_WIDTH(8), .K_WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .trigger    (trigger),
        .N          (n),
        .data_out   (d4),
        .busy       (b4),
        .lights_out (l4)
    );

    function automatic int lfsr_next(input int v, input int k);
        int fb;
        if (k == 7) fb = ((v >> 6) ^ (v >> 5)) & 1;
        else        fb = ((v >> 3) ^ (v >> 2)) & 1;
        return ((v << 1) | fb) & ((1 << k) - 1);
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_out(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got data=%h busy=%b lo=%b expected data=%h busy=%b lo=%b",
                     name, cyc, act.data, act.busy, act.lo, exp.data, exp.busy, exp.lo);
        end
    endtask

    // Expected state after the coming edge, in terms of enabled cycles since start.
    task automatic model_step(input int i);
        int k;
        if (rst) begin
            m_data[i] = 8'h00;
            m_busy[i] = 0;
            m_lo[i]   = 0;
            m_lfsr[i] = 1;
            m_cnt[i]  = 0;
        end else begin
            m_lo[i] = 0;
            if (en) begin
                if (!m_busy[i]) begin
                    if (trigger) begin
                        m_busy[i] = 1;
                        m_cnt[i]  = 0;
                        m_per[i]  = int'(n) + 1;
                    end
                end else begin
                    m_cnt[i]++;
                    if (m_cnt[i] % m_per[i] == 0) begin
                        k = m_cnt[i] / m_per[i];
                        if (k <= 8) begin
                            m_data[i] = 8'((1 << k) - 1);
                            if (k == 8) m_h[i] = m_lfsr[i];
                        end else if (k == 8 + m_h[i]) begin
                            m_data[i] = 8'h00;
                            m_lo[i]   = 1;
                            m_busy[i] = 0;
                        end
                    end
                end
                m_lfsr[i] = lfsr_next(m_lfsr[i], kw[i]);
            end
        end
    endtask

    // One clock: drive, push expectations, then pop and compare after the edge.
    task automatic cycle(input bit r, input bit e, input bit t);
        exp_t x;
        int   h;
        rst     = r;
        en      = e;
        trigger = t;
        model_step(0);
        model_step(1);
        sb7.push_back(exp_t'({m_data[0], m_busy[0], m_lo[0]}));
        sb4.push_back(exp_t'({m_data[1], m_busy[1], m_lo[1]}));
        @(posedge clk);
        @(negedge clk);
        cyc++;
        x = sb7.pop_front();
        check_out("sb_k7", exp_t'({d7, b7, l7}), x);
        x = sb4.pop_front();
        check_out("sb_k4", exp_t'({d4, b4, l4}), x);
        if (hmon) begin
            if (d4 == 8'hFF && prev_d4 != 8'hFF) hstart = cyc;
            if (l4) begin
                h = cyc - hstart;
                n_checks++;
                if (h < 1 || h > 15) begin
                    n_errors++;
                    $display("FAIL hold_range_k4 cycle=%0d got H=%0d expected 1..15", cyc, h);
                end
                hseq++;
            end
        end
        prev_d4 = d4;
    endtask

    task automatic run_idle(input int max);
        int c = 0;
        while ((b7 || b4) && c < max) begin
            cycle(0, 1, 0);
            c++;
        end
        check_val("idle_timeout", {30'd0, b7, b4}, 32'd0);
    endtask

    initial begin
        logic [7:0] saved;
        int         c;
        rst = 1; en = 1; trigger = 1; n = 16'd0;

        // Reset with trigger high, then an N=0 fill including one en=0 cycle.
        tbl[0]  = '{1, 1, 1, 8'h00, 0, 0};
        tbl[1]  = '{1, 1, 1, 8'h00, 0, 0};
        tbl[2]  = '{0, 1, 1, 8'h00, 1, 0};
        tbl[3]  = '{0, 1, 0, 8'h01, 1, 0};
        tbl[4]  = '{0, 1, 0, 8'h03, 1, 0};
        tbl[5]  = '{0, 0, 0, 8'h03, 1, 0};
        tbl[6]  = '{0, 1, 0, 8'h07, 1, 0};
        tbl[7]  = '{0, 1, 1, 8'h0F, 1, 0};
        tbl[8]  = '{0, 1, 0, 8'h1F, 1, 0};
        tbl[9]  = '{0, 1, 0, 8'h3F, 1, 0};
        tbl[10] = '{0, 1, 0, 8'h7F, 1, 0};
        tbl[11] = '{0, 1, 0, 8'hFF, 1, 0};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].en, tbl[i].trig);
            check_out("tbl_k7", exp_t'({d7, b7, l7}), exp_t'({tbl[i].data, tbl[i].busy, tbl[i].lo}));
            check_out("tbl_k4", exp_t'({d4, b4, l4}), exp_t'({tbl[i].data, tbl[i].busy, tbl[i].lo}));
        end
        run_idle(400);

        // N=3 fill: one new light every 4 edges.
        n = 16'd3;
        cycle(0, 1, 1);
        for (int k = 1; k <= 32; k++) begin
            cycle(0, 1, 0);
            if (k % 4 == 0) check_val("fill_n3", {24'd0, d7}, 32'((1 << (k / 4)) - 1));
        end
        run_idle(1200);

        // en dropped for 5 cycles mid-fill: pattern frozen.
        cycle(0, 1, 1);
        for (int k = 0; k < 10; k++) cycle(0, 1, 0);
        saved = d7;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0);
            check_val("en_freeze", {24'd0, d7}, {24'd0, saved});
        end
        run_idle(1200);

        // Trigger pulses during FILL and HOLD are ignored; lights_out clears with en=0.
        cycle(0, 1, 1);
        for (int k = 0; k < 6; k++) cycle(0, 1, 0);
        cycle(0, 1, 1);
        for (int k = 0; k < 26; k++) cycle(0, 1, 0);
        check_val("hold_full", {24'd0, d7}, 32'h0000_00FF);
        cycle(0, 1, 1);
        c = 0;
        while (!l7 && c < 1200) begin
            cycle(0, 1, 0);
            c++;
        end
        check_val("lo_seen", {31'd0, l7}, 32'd1);
        cycle(0, 0, 0);
        check_val("lo_clear_en0", {31'd0, l7}, 32'd0);
        run_idle(1200);

        // Reset mid-HOLD: lights off, no pulse; following sequence uses a fresh LFSR.
        n = 16'd1;
        cycle(0, 1, 1);
        for (int k = 0; k < 17; k++) cycle(0, 1, 0);
        check_val("pre_rst_hold", {24'd0, d7}, 32'h0000_00FF);
        cycle(1, 1, 0);
        check_out("rst_hold", exp_t'({d7, b7, l7}), exp_t'({8'h00, 1'b0, 1'b0}));
        cycle(0, 1, 0);
        check_val("rst_no_lo", {31'd0, l7}, 32'd0);
        n = 16'd0;
        cycle(0, 1, 1);
        run_idle(400);

        // Trigger held high with N=0: back-to-back sequences, hold range on K=4.
        hmon = 1;
        c = 0;
        while (hseq < 50 && c < 5000) begin
            cycle(0, 1, 1);
            c++;
        end
        hmon = 0;
        check_val("hold_seq_count", {31'd0, (hseq >= 50)}, 32'd1);
        cycle(0, 1, 0);
        run_idle(400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_f1_light_sequencer
`default_nettype wire
